// File: rtl/usb_proto_ctrl_pkg.sv
// usb_pkg: shared PID, encoder-kind and FSM-state types plus PID classification helpers
// for the usb_proto_ctrl slice.
package usb_pkg;
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } usb_pid_t;
  typedef enum logic [1:0] {KIND_TOKEN, KIND_DATA, KIND_HSHK} enc_kind_t;
  typedef enum logic [2:0] {ST_IDLE, ST_TOKEN, ST_DATA_TX, ST_HS_WAIT, ST_DATA_WAIT, ST_HS_TX} proto_state_t;
  function automatic logic is_data(input logic [3:0] pid);
    return pid == PID_DATA0 || pid == PID_DATA1;
  endfunction
  function automatic logic [3:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction
endpackage

// File: rtl/usb_proto_ctrl_if.sv
// usb_proto_ctrl_if: request/response, encoder and decoder signals of the transaction controller.
// master = controller view, slave = read/write layer plus encoder/decoder view.
interface usb_proto_ctrl_if #(parameter int DW = 64, parameter int NUM_EP = 4);
  logic req_valid, req_ready, req_dir;
  logic [6:0] req_addr;
  logic [3:0] req_endp;
  logic [DW-1:0] req_data;
  logic done, success, stalled;
  logic [DW-1:0] rsp_data;
  logic [NUM_EP-1:0] toggle_clr;
  logic enc_valid, enc_ready;
  usb_pkg::enc_kind_t enc_kind;
  logic [3:0] enc_pid;
  logic [6:0] enc_addr;
  logic [3:0] enc_endp;
  logic [DW-1:0] enc_data;
  logic dec_valid, dec_crc_ok;
  logic [3:0] dec_pid;
  logic [DW-1:0] dec_data;
  logic nrzi_idle, re;
  modport master (
    input  req_valid, req_dir, req_addr, req_endp, req_data, toggle_clr, enc_ready,
           dec_valid, dec_crc_ok, dec_pid, dec_data, nrzi_idle,
    output req_ready, done, success, stalled, rsp_data, enc_valid, enc_kind, enc_pid,
           enc_addr, enc_endp, enc_data, re
  );
  modport slave (
    output req_valid, req_dir, req_addr, req_endp, req_data, toggle_clr, enc_ready,
           dec_valid, dec_crc_ok, dec_pid, dec_data, nrzi_idle,
    input  req_ready, done, success, stalled, rsp_data, enc_valid, enc_kind, enc_pid,
           enc_addr, enc_endp, enc_data, re
  );
endinterface

// File: rtl/usb_timeout_timer.sv
// usb_timeout_timer: wait-state cycle counter; timeout flags the TIMEOUT-th cycle while enabled.
module usb_timeout_timer #(parameter int TIMEOUT = 255) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  assign timeout = en && r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_cnt <= '0;
    else if (clr || timeout) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + CW'(1);
endmodule

// File: rtl/usb_proto_ctrl.sv
// usb_proto_ctrl: host-side USB OUT/IN transaction FSM with retries, timeout and STALL handling.
// Define USB_PROTO_TOGGLE_EN for the per-endpoint DATA0/DATA1 toggle table and duplicate detection.
module usb_proto_ctrl import usb_pkg::*; #(
  parameter int DATA_BYTES = 8,
  parameter int MAX_ERR    = 8,
  parameter int TIMEOUT    = 255,
  parameter int NUM_EP     = 4
) (
  input logic clk,
  input logic rst_b,
  usb_proto_ctrl_if.master bus
);
  localparam int DW  = 8 * DATA_BYTES;
  localparam int EW  = $clog2(MAX_ERR + 1);
  localparam int EPW = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  proto_state_t r_state;
  logic r_dir, r_dup, r_done, r_success, r_stalled, r_re, r_enc_valid;
  logic [DW-1:0] r_data, r_rsp_data, r_enc_data;
  logic [EW-1:0] r_err;
  enc_kind_t r_enc_kind;
  logic [3:0] r_enc_pid, r_enc_endp;
  logic [6:0] r_enc_addr;
  logic w_wait, w_timeout, w_hs, w_ok, w_last, w_tog, w_new, w_flip;
  assign w_wait = r_state == ST_HS_WAIT || r_state == ST_DATA_WAIT;
  assign w_hs   = r_enc_valid && bus.enc_ready;
  assign w_ok   = bus.dec_valid && bus.dec_crc_ok;
  assign w_last = r_err == EW'(MAX_ERR - 1);
  assign w_flip = w_ok && ((r_state == ST_HS_WAIT && bus.dec_pid == PID_ACK) ||
                           (r_state == ST_DATA_WAIT && is_data(bus.dec_pid) && w_new));
  usb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst_b(rst_b), .clr(!w_wait), .en(w_wait), .timeout(w_timeout)
  );
`ifdef USB_PROTO_TOGGLE_EN
  logic [NUM_EP-1:0] r_toggle;
  logic [EPW-1:0] w_ep;
  assign w_ep  = r_enc_endp[EPW-1:0];
  assign w_tog = r_toggle[w_ep];
  assign w_new = bus.dec_pid == data_pid(w_tog);
  // A clear requested in the same cycle as a flip leaves the endpoint at DATA0.
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) r_toggle <= '0;
    else for (int i = 0; i < NUM_EP; i++)
      if (bus.toggle_clr[i]) r_toggle[i] <= 1'b0;
      else if (w_flip && w_ep == EPW'(i)) r_toggle[i] <= ~r_toggle[i];
`else
  logic w_unused;
  assign w_tog    = 1'b0;
  assign w_new    = 1'b1;
  assign w_unused = ^{bus.toggle_clr, w_flip};
`endif
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_dir <= 1'b0;
      r_dup <= 1'b0;
      r_data <= '0;
      r_err <= '0;
      r_done <= 1'b0;
      r_success <= 1'b0;
      r_stalled <= 1'b0;
      r_re <= 1'b0;
      r_rsp_data <= '0;
      r_enc_valid <= 1'b0;
      r_enc_kind <= KIND_TOKEN;
      r_enc_pid <= '0;
      r_enc_addr <= '0;
      r_enc_endp <= '0;
      r_enc_data <= '0;
    end else begin
      r_done <= 1'b0;
      r_re <= w_wait && bus.nrzi_idle;
      case (r_state)
        ST_IDLE: if (bus.req_valid) begin
          r_dir <= bus.req_dir;
          r_data <= bus.req_data;
          r_err <= '0;
          r_dup <= 1'b0;
          r_success <= 1'b0;
          r_stalled <= 1'b0;
          r_state <= ST_TOKEN;
          r_enc_valid <= 1'b1;
          r_enc_kind <= KIND_TOKEN;
          r_enc_pid <= bus.req_dir ? PID_IN : PID_OUT;
          r_enc_addr <= bus.req_addr;
          r_enc_endp <= bus.req_endp;
        end
        ST_TOKEN: if (w_hs) begin
          r_state <= r_dir ? ST_DATA_WAIT : ST_DATA_TX;
          r_enc_valid <= !r_dir;
          if (!r_dir) begin
            r_enc_kind <= KIND_DATA;
            r_enc_pid <= data_pid(w_tog);
            r_enc_data <= r_data;
          end
        end
        ST_DATA_TX: if (w_hs) begin
          r_state <= ST_HS_WAIT;
          r_enc_valid <= 1'b0;
        end
        // The encoder registers still hold the DATA packet, so a retry only re-raises valid.
        ST_HS_WAIT:
          if (w_ok && (bus.dec_pid == PID_ACK || bus.dec_pid == PID_STALL)) begin
            r_state <= ST_IDLE;
            r_done <= 1'b1;
            r_success <= bus.dec_pid == PID_ACK;
            r_stalled <= bus.dec_pid == PID_STALL;
          end else if (bus.dec_valid || w_timeout) begin
            r_state <= w_last ? ST_IDLE : ST_DATA_TX;
            r_done <= w_last;
            r_enc_valid <= !w_last;
            r_err <= r_err + EW'(1);
          end
        ST_DATA_WAIT:
          if (w_ok && is_data(bus.dec_pid)) begin
            if (w_new) r_rsp_data <= bus.dec_data;
            r_dup <= !w_new;
            r_state <= ST_HS_TX;
            r_enc_valid <= 1'b1;
            r_enc_kind <= KIND_HSHK;
            r_enc_pid <= PID_ACK;
          end else if (w_ok && bus.dec_pid == PID_STALL) begin
            r_state <= ST_IDLE;
            r_done <= 1'b1;
            r_stalled <= 1'b1;
          end else if (bus.dec_valid || w_timeout) begin
            r_state <= w_last ? ST_IDLE : ST_TOKEN;
            r_done <= w_last;
            r_enc_valid <= !w_last;
            r_err <= r_err + EW'(1);
          end
        ST_HS_TX: if (w_hs) begin
          r_state <= (!r_dup || w_last) ? ST_IDLE : ST_TOKEN;
          r_done <= !r_dup || w_last;
          r_success <= !r_dup;
          r_enc_valid <= r_dup && !w_last;
          r_enc_kind <= KIND_TOKEN;
          r_enc_pid <= PID_IN;
          if (r_dup) r_err <= r_err + EW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign bus.req_ready = r_state == ST_IDLE;
  assign bus.done      = r_done;
  assign bus.success   = r_success;
  assign bus.stalled   = r_stalled;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.enc_valid = r_enc_valid;
  assign bus.enc_kind  = r_enc_kind;
  assign bus.enc_pid   = r_enc_pid;
  assign bus.enc_addr  = r_enc_addr;
  assign bus.enc_endp  = r_enc_endp;
  assign bus.enc_data  = r_enc_data;
  assign bus.re        = r_re;
endmodule

// File: tb/tb_usb_proto_ctrl.sv
// tb_usb_proto_ctrl: directed transactions; expected packets/completions are queued and
// checked by an independent monitor against what the controller emits.
module tb_usb_proto_ctrl;
  import usb_pkg::*;
  localparam int DW = 64, MAX_ERR = 8, TIMEOUT = 255, NUM_EP = 4, LIMIT = 4000;
`ifdef USB_PROTO_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif
  typedef struct {
    bit is_done;
    logic [1:0] kind;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [DW-1:0] data;
    bit chk_data;
    int gap;
    bit succ;
    bit stl;
  } exp_t;
  logic clk = 1'b0, rst_b = 1'b0;
  exp_t q[$];
  int n_vec = 0, n_err = 0, cyc = 0, last_hs = 0;
  logic [DW-1:0] exp_rsp = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  usb_proto_ctrl_if #(.DW(DW), .NUM_EP(NUM_EP)) bus ();
  usb_proto_ctrl #(.DATA_BYTES(8), .MAX_ERR(MAX_ERR), .TIMEOUT(TIMEOUT), .NUM_EP(NUM_EP)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus)
  );
  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic void push_enc(input logic [1:0] k, input logic [3:0] p, input logic [6:0] a,
                                   input logic [3:0] e, input logic [DW-1:0] d, input bit cd, input int g);
    exp_t x;
    x.is_done = 0; x.kind = k; x.pid = p; x.addr = a; x.endp = e;
    x.data = d; x.chk_data = cd; x.gap = g; x.succ = 0; x.stl = 0;
    q.push_back(x);
  endfunction
  function automatic void push_done(input bit s, input bit st, input logic [DW-1:0] r);
    exp_t x;
    x.is_done = 1; x.kind = '0; x.pid = '0; x.addr = '0; x.endp = '0;
    x.data = r; x.chk_data = 1; x.gap = 0; x.succ = s; x.stl = st;
    q.push_back(x);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && bus.enc_valid && bus.enc_ready) begin
      if (q.size() == 0 || q[0].is_done) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_enc: got kind %0d pid %b, no packet expected here", bus.enc_kind, bus.enc_pid);
      end else begin
        e = q.pop_front();
        chk("enc_kind", bus.enc_kind, e.kind);
        chk("enc_pid", bus.enc_pid, e.pid);
        chk("enc_addr", bus.enc_addr, e.addr);
        chk("enc_endp", bus.enc_endp, e.endp);
        if (e.chk_data) chk("enc_data", bus.enc_data, e.data);
        if (e.gap != 0) chk("enc_gap", cyc - last_hs, e.gap);
      end
      last_hs = cyc;
    end
    if (rst_b && bus.done) begin
      if (q.size() == 0 || !q[0].is_done) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got success %b stalled %b, no completion expected here", bus.success, bus.stalled);
      end else begin
        e = q.pop_front();
        chk("success", bus.success, e.succ);
        chk("stalled", bus.stalled, e.stl);
        chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end
  task automatic send_req(input logic dir, input logic [6:0] a, input logic [3:0] e, input logic [DW-1:0] d);
    int i = 0;
    while (!bus.req_ready && i < LIMIT) begin @(negedge clk); i++; end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_dir = dir; bus.req_addr = a; bus.req_endp = e; bus.req_data = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_hs();
    int i = 0;
    while (!(bus.enc_valid && bus.enc_ready) && i < LIMIT) begin @(negedge clk); i++; end
    chk("enc_hs_wait", bus.enc_valid && bus.enc_ready, 1);
    @(negedge clk);
  endtask
  task automatic wait_done();
    int i = 0;
    while (!bus.done && i < LIMIT) begin @(negedge clk); i++; end
    chk("done_wait", bus.done, 1);
    @(negedge clk);
  endtask
  task automatic dec_pulse(input logic [3:0] p, input logic c, input logic [DW-1:0] d, input logic [NUM_EP-1:0] clr);
    bus.dec_valid = 1'b1; bus.dec_pid = p; bus.dec_crc_ok = c; bus.dec_data = d; bus.toggle_clr = clr;
    @(negedge clk);
    bus.dec_valid = 1'b0; bus.dec_crc_ok = 1'b0; bus.toggle_clr = '0;
  endtask
  // n_nak failed attempts (the second one a bad-CRC ACK) precede the final ACK or STALL.
  task automatic do_out(input logic [6:0] a, input logic [3:0] e, input logic [DW-1:0] d, input logic [3:0] dp,
                        input int n_nak, input bit stall, input logic [NUM_EP-1:0] clr);
    push_enc(KIND_TOKEN, PID_OUT, a, e, '0, 0, 0);
    for (int i = 0; i <= n_nak; i++) push_enc(KIND_DATA, dp, a, e, d, 1, 0);
    push_done(!stall, stall, exp_rsp);
    send_req(1'b0, a, e, d);
    wait_hs();
    for (int i = 0; i <= n_nak; i++) begin
      wait_hs();
      if (i < n_nak) dec_pulse(i == 1 ? PID_ACK : PID_NAK, i != 1, '0, '0);
      else dec_pulse(stall ? PID_STALL : PID_ACK, 1'b1, '0, clr);
    end
    wait_done();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 0; bus.req_dir = 0; bus.req_addr = '0; bus.req_endp = '0; bus.req_data = '0;
    bus.toggle_clr = '0; bus.enc_ready = 1; bus.dec_valid = 0; bus.dec_crc_ok = 0;
    bus.dec_pid = '0; bus.dec_data = '0; bus.nrzi_idle = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_enc_valid", bus.enc_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_success", bus.success, 0);
    chk("rst_stalled", bus.stalled, 0);
    chk("rst_re", bus.re, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_enc_pid", bus.enc_pid, 0);
    rst_b = 1'b1;
    @(negedge clk);
    do_out(7'h12, 4'd1, 64'h0123_4567_89AB_CDEF, PID_DATA0, 0, 0, '0);
    do_out(7'h12, 4'd1, 64'hDEAD_BEEF_0000_0001, TOG ? PID_DATA1 : PID_DATA0, 0, 0, '0);
    do_out(7'h2A, 4'd3, 64'h1111_2222_3333_4444, PID_DATA0, 3, 0, '0);
    push_enc(KIND_TOKEN, PID_IN, 7'h05, 4'd0, '0, 0, 0);
    for (int i = 1; i < MAX_ERR; i++) push_enc(KIND_TOKEN, PID_IN, 7'h05, 4'd0, '0, 0, TIMEOUT + 1);
    push_done(0, 0, exp_rsp);
    send_req(1'b1, 7'h05, 4'd0, '0);
    repeat (3) @(negedge clk);
    chk("re_in_wait", bus.re, 1);
    chk("req_ready_busy", bus.req_ready, 0);
    wait_done();
    push_enc(KIND_TOKEN, PID_IN, 7'h05, 4'd2, '0, 0, 0);
    push_enc(KIND_HSHK, PID_ACK, 7'h05, 4'd2, '0, 0, 0);
    if (TOG) begin
      push_enc(KIND_TOKEN, PID_IN, 7'h05, 4'd2, '0, 0, 0);
      push_enc(KIND_HSHK, PID_ACK, 7'h05, 4'd2, '0, 0, 0);
      exp_rsp = 64'hA5A5_0000_2222_0002;
    end else exp_rsp = 64'h5A5A_0000_1111_0001;
    push_done(1, 0, exp_rsp);
    send_req(1'b1, 7'h05, 4'd2, '0);
    wait_hs();
    dec_pulse(PID_DATA1, 1'b1, 64'h5A5A_0000_1111_0001, '0);
    wait_hs();
    if (TOG) begin
      chk("dup_rsp_unchanged", bus.rsp_data, 0);
      wait_hs();
      dec_pulse(PID_DATA0, 1'b1, 64'hA5A5_0000_2222_0002, '0);
      wait_hs();
    end
    wait_done();
    do_out(7'h12, 4'd1, 64'h4444_0000_0000_0004, PID_DATA0, 0, 1, '0);
    do_out(7'h12, 4'd1, 64'h5555_0000_0000_0005, PID_DATA0, 0, 0, '0);
    do_out(7'h07, 4'd2, 64'h6666_0000_0000_0006, TOG ? PID_DATA1 : PID_DATA0, 0, 0, '0);
    do_out(7'h07, 4'd2, 64'h7777_0000_0000_0007, PID_DATA0, 0, 0, 4'b0100);
    do_out(7'h07, 4'd2, 64'h8888_0000_0000_0008, PID_DATA0, 0, 0, '0);
    push_enc(KIND_TOKEN, PID_OUT, 7'h33, 4'd0, '0, 0, 0);
    push_enc(KIND_DATA, PID_DATA0, 7'h33, 4'd0, 64'h9999_0000_0000_0009, 1, 0);
    send_req(1'b0, 7'h33, 4'd0, 64'h9999_0000_0000_0009);
    wait_hs();
    wait_hs();
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_enc_valid", bus.enc_valid, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_success", bus.success, 0);
    chk("mid_rst_stalled", bus.stalled, 0);
    chk("mid_rst_re", bus.re, 0);
    chk("mid_rst_rsp_data", bus.rsp_data, 0);
    chk("mid_rst_enc_data", bus.enc_data, 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usb_proto_ctrl.md
# usb_proto_ctrl

Parametrised host-side USB transaction controller, successor to the single-endpoint protocol FSM. It sits between the read/write layer and the bit-stuff/NRZI encoder and decoder. It runs OUT and IN transactions with configurable payload width, retry limit and timeout, and tracks DATA0/DATA1 per endpoint. It handles STALL, and applies USB host rules to IN errors: no NAK is sent and the token is reissued.

## Interface
- DATA_BYTES, 8: payload bytes per DATA packet; DW = 8*DATA_BYTES.
- MAX_ERR, 8: errors before failure, ≥1.
- TIMEOUT, 255: cycles in a wait state before timeout, ≥2.
- NUM_EP, 4: endpoints with toggle state. Only the low $clog2(NUM_EP) bits of endp index the table.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid / req_ready  in / out  1  request handshake. req_ready is high only in IDLE.
- req_dir  in  1  0 = OUT, 1 = IN.
- req_addr  in  7  device address. req_endp  in  4  endpoint. req_data  in  DW  OUT payload.
- done  out  1  one-cycle completion pulse.
- success / stalled  out  1  result. Held from done until the next accepted request.
- rsp_data  out  DW  IN payload. Updated only on successful IN.
- toggle_clr  in  NUM_EP  per-endpoint synchronous clear to DATA0.
- enc_valid / enc_ready  out / in  1  encoder handshake.
- enc_kind  out  2  TOKEN, DATA, HSHK. enc_pid  out  4. enc_addr  out  7. enc_endp  out  4. enc_data  out  DW.
- dec_valid  in  1  one-cycle packet strobe. dec_crc_ok  in  1. dec_pid  in  4. dec_data  in  DW.
- nrzi_idle  in  1  line idle. re  out  1  receiver enable.

## Operation
- PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- A packet is "good" when dec_valid && dec_crc_ok and the PID is legal for the state. Any other dec_valid is corrupt.
- States:
  - IDLE: req_valid && req_ready latches all req_* fields, clears err, then goes to TOKEN.
  - TOKEN: enc_valid = 1, kind TOKEN, pid OUT or IN. On handshake: OUT → DATA_TX, IN → DATA_WAIT.
  - DATA_TX: kind DATA, pid from toggle[endp], enc_data = latched payload. On handshake → HS_WAIT.
  - HS_WAIT:
    - ACK: flip toggle, finish success.
    - STALL: finish with stalled = 1, success = 0.
    - NAK, corrupt or timeout: err++, then DATA_TX, or finish failure if err reaches MAX_ERR.
  - DATA_WAIT:
    - DATA with the expected toggle: capture rsp_data, flip toggle, go to HS_TX.
    - DATA with the wrong toggle (duplicate): discard the payload, no flip, go to HS_TX with the dup flag set.
    - STALL: finish stalled.
    - NAK, corrupt or timeout: no handshake is sent, err++, then TOKEN, or finish failure at MAX_ERR.
  - HS_TX: kind HSHK, pid ACK. On handshake: finish success, or if dup then err++ and go to TOKEN (or fail at MAX_ERR).
- Finish means: done pulses, then the FSM returns to IDLE.
- Retry budget: err width is $clog2(MAX_ERR+1). The MAX_ERR-th error terminates, giving MAX_ERR total attempts.
- Timer: cleared on entry to HS_WAIT or DATA_WAIT, counts while in them. Timeout fires when count == TIMEOUT-1.
- Simultaneous events:
  - dec_valid wins over timeout in the same cycle.
  - toggle_clr wins over a flip of the same endpoint.
  - dec_valid outside the wait states is ignored.
- Outputs are held stable while enc_valid && !enc_ready.

## Timing
- Reset values: FSM in IDLE. done, success, stalled, enc_valid, re = 0. enc_*, rsp_data = 0. All toggles DATA0. err and timer = 0.
- Reset mid-transaction aborts it with no done pulse.
- req accepted at edge N → enc_valid high from cycle N+1.
- Decoder event at edge N → next state from N+1. done is asserted in the cycle the FSM leaves its last state.
- re is registered: re = (state is HS_WAIT or DATA_WAIT) && nrzi_idle, one cycle late.
- Zero-wait encoder: a successful OUT takes 2 enc handshakes plus the device response.

## Configuration
- USB_PROTO_TOGGLE_EN defined: per-endpoint toggle table, duplicate detection and toggle_clr behave as above.
- Not defined: no toggle storage. DATA_TX always sends DATA0, and DATA_WAIT accepts DATA0 or DATA1 as new data. toggle_clr is ignored.

## Structure
- Package usb_pkg holds the usb_pid_t enum (PIDs above), enc_kind_t enum, proto_state_t enum, and the PID check helpers.
- Sub-module usb_timeout_timer, parameter TIMEOUT, ports clk, rst_b, clr, en, timeout.

## Test plan
- OUT, device ACKs after 1 cycle → DATA0 sent, done with success = 1; the next OUT to the same endp sends DATA1.
- OUT, device NAKs 3 times then ACKs → 4 DATA_TX packets, success = 1, err = 3 before finish.
- IN with no response and MAX_ERR = 8 → 8 IN tokens each separated by TIMEOUT cycles, no handshake sent, success = 0.
- IN, good DATA1 while expecting DATA0 → ACK sent, rsp_data unchanged, token reissued. Then DATA0 → rsp_data updated, success = 1.
- OUT answered with STALL → done after one DATA packet, stalled = 1, success = 0, toggle unchanged.
- toggle_clr[2] pulsed in the same cycle as an ACK on endp 2 → toggle[2] = DATA0. Reset asserted mid-HS_WAIT → all outputs 0, no done.
